// File: rtl/rv0_pipe_sbuf.sv
// rv0_pipe_sbuf: DEPTH-entry circular skid buffer between two core pipeline
// stages (rdy/ack handshake). The upstream ack is registered from state only,
// so downstream ack never reaches upstream ack combinationally.
// Optional build macro RV0_PIPE_SBUF_BYPASS_EN adds a zero-latency
// pass-through when the buffer is empty.
module rv0_pipe_sbuf #(
  parameter int XLEN      = 32,
  parameter int FLEN      = 32,
  parameter int DEPTH     = 2,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [XLEN-1:0]        s_insn,
  input  logic [31:0]            s_addr,
  input  logic [XLEN-1:0]        s_idata1,
  input  logic [XLEN-1:0]        s_idata2,
  input  logic [FLEN-1:0]        s_fdata1,
  input  logic [FLEN-1:0]        s_fdata2,
  input  logic [31:0]            s_tags,
  input  logic                   s_rdy,
  output logic                   s_ack,
  output logic [XLEN-1:0]        m_insn,
  output logic [31:0]            m_addr,
  output logic [XLEN-1:0]        m_idata1,
  output logic [XLEN-1:0]        m_idata2,
  output logic [FLEN-1:0]        m_fdata1,
  output logic [FLEN-1:0]        m_fdata2,
  output logic [31:0]            m_tags,
  output logic                   m_rdy,
  input  logic                   m_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic                   s_afull
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int PLW = 3 * XLEN + 2 * FLEN + 64;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LVL);

  logic [PLW-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           s_ack_q, s_ack_d;
  logic           s_afull_q, s_afull_d;

  logic [PLW-1:0] s_pl;
  logic [PLW-1:0] m_pl;
  logic           empty;
  logic           byp_sel;
  logic           byp_xfer;
  logic           push;
  logic           pop;

  assign s_pl  = {s_insn, s_addr, s_idata1, s_idata2, s_fdata1, s_fdata2, s_tags};
  assign empty = (level_q == '0);

`ifdef RV0_PIPE_SBUF_BYPASS_EN
  // Bypass is chosen purely from occupancy; m_ack only decides whether the
  // passing payload is also captured.
  assign byp_sel = empty & ~flush;
`else
  assign byp_sel = 1'b0;
`endif

  // Upstream offer is only real when our registered ack is high, so a bypass
  // transfer requires it too; otherwise the source would see no handshake.
  assign byp_xfer = byp_sel & s_rdy & s_ack_q & m_ack;
  assign push     = s_rdy & s_ack_q & ~flush & ~byp_xfer;
  assign pop      = ~empty & m_ack & ~flush;

  assign m_pl  = byp_sel ? s_pl : mem_q[rd_ptr_q];
  assign m_rdy = byp_sel ? (s_rdy & s_ack_q) : ~empty;

  assign {m_insn, m_addr, m_idata1, m_idata2, m_fdata1, m_fdata2, m_tags} = m_pl;

  assign s_ack   = s_ack_q;
  assign level   = level_q;
  assign s_afull = s_afull_q;

  // Next-state for pointers, occupancy and the registered status flags.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
    s_ack_d   = (level_d < DEPTH_L) & ~flush;
    s_afull_d = (level_d >= AFULL_L);
  end

  // Control state; s_ack comes up on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      s_ack_q   <= 1'b0;
      s_afull_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      s_ack_q   <= s_ack_d;
      s_afull_q <= s_afull_d;
    end
  end

  // Payload storage; entries are cleared on reset so m_* reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= s_pl;
    end
  end

endmodule

// File: tb/tb_rv0_pipe_sbuf.sv
// tb_rv0_pipe_sbuf: directed vector table plus a queue scoreboard that tracks
// occupancy, upstream ack and FIFO order every cycle (DEPTH=4, AFULL_LVL=3).
module tb_rv0_pipe_sbuf;

  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic [31:0] idata1;
    logic [31:0] idata2;
    logic [31:0] fdata1;
    logic [31:0] fdata2;
    logic [31:0] tags;
  } pl_t;

  typedef struct {
    logic        s_rdy;
    logic        m_ack;
    logic        flush;
    logic [31:0] addr;
    logic        e_mrdy;
    logic        e_sack;
    logic [2:0]  e_lvl;
    logic        e_af;
    logic        ca;
    logic [31:0] e_maddr;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        s_rdy;
  logic        m_ack;
  pl_t         sp;
  logic        s_ack;
  logic [31:0] m_insn, m_addr, m_idata1, m_idata2, m_fdata1, m_fdata2, m_tags;
  logic        m_rdy;
  logic [2:0]  level;
  logic        s_afull;

  pl_t q[$];
  pl_t prev;
  bit  exp_ack;
  bit  hold_prev;
  int  npop;
  int  total;
  int  bad;

  rv0_pipe_sbuf #(
    .XLEN(32), .FLEN(32), .DEPTH(DEPTH), .AFULL_LVL(AFULL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_insn(sp.insn), .s_addr(sp.addr), .s_idata1(sp.idata1), .s_idata2(sp.idata2),
    .s_fdata1(sp.fdata1), .s_fdata2(sp.fdata2), .s_tags(sp.tags),
    .s_rdy(s_rdy), .s_ack(s_ack),
    .m_insn(m_insn), .m_addr(m_addr), .m_idata1(m_idata1), .m_idata2(m_idata2),
    .m_fdata1(m_fdata1), .m_fdata2(m_fdata2), .m_tags(m_tags),
    .m_rdy(m_rdy), .m_ack(m_ack), .level(level), .s_afull(s_afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pl_t mk(input logic [31:0] a);
    pl_t p;
    p.insn   = 32'h0000_0013 ^ {a[29:0], 2'b00};
    p.addr   = a;
    p.idata1 = ~a;
    p.idata2 = a * 32'd3;
    p.fdata1 = a ^ 32'hdead_beef;
    p.fdata2 = {a[15:0], a[31:16]};
    p.tags   = 32'h0000_0001 ^ {a[30:0], 1'b0};
    return p;
  endfunction

  function automatic vec_t v(input logic sr, input logic ma, input logic fl,
                             input logic [31:0] a, input logic er, input logic es,
                             input logic [2:0] el, input logic ef, input logic c,
                             input logic [31:0] ea);
    vec_t r;
    r.s_rdy = sr; r.m_ack = ma; r.flush = fl; r.addr = a;
    r.e_mrdy = er; r.e_sack = es; r.e_lvl = el; r.e_af = ef; r.ca = c; r.e_maddr = ea;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [223:0] act, input logic [223:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: check current outputs, then advance the model by the inputs
  // that will take effect at the coming clock edge.
  task automatic model_step();
    pl_t act;
    act = {m_insn, m_addr, m_idata1, m_idata2, m_fdata1, m_fdata2, m_tags};
    if (!rst_n) begin
      chk("rst_s_ack", 224'(s_ack), 224'(0));
      chk("rst_m_rdy", 224'(m_rdy), 224'(0));
      chk("rst_level", 224'(level), 224'(0));
      chk("rst_payload", act, 224'(0));
      q.delete();
      exp_ack   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      chk("level", 224'(level), 224'(q.size()));
      chk("m_rdy", 224'(m_rdy), 224'(q.size() != 0));
      chk("s_ack", 224'(s_ack), 224'(exp_ack));
      chk("s_afull", 224'(s_afull), 224'(q.size() >= AFULL));
      if (hold_prev) chk("hold", act, prev);
      if (q.size() != 0) chk("order", act, q[0]);
      hold_prev = m_rdy && !m_ack && !flush;
      prev      = act;
      if (flush) begin
        q.delete();
        exp_ack = 1'b0;
      end else begin
        if (q.size() != 0 && m_ack) begin
          void'(q.pop_front());
          npop++;
        end
        if (s_rdy && exp_ack) q.push_back(sp);
        exp_ack = (q.size() < DEPTH);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[21];

  initial begin
    int n0;
    int cyc;
    pl_t act;
    total = 0; bad = 0; npop = 0;
    exp_ack = 1'b0; hold_prev = 1'b0; prev = '0;
    rst_n = 1'b0; flush = 1'b0; s_rdy = 1'b0; m_ack = 1'b0; sp = '0;

    //            s_rdy m_ack flush addr          m_rdy s_ack lvl af ca m_addr
    tbl[0]  = v(0, 0, 0, 32'h0,        0, 0, 3'd0, 0, 1, 32'h0);
    tbl[1]  = v(0, 0, 0, 32'h0,        0, 1, 3'd0, 0, 1, 32'h0);
    tbl[2]  = v(1, 1, 0, 32'h8000_0000, 0, 1, 3'd0, 0, 1, 32'h0);
    tbl[3]  = v(0, 1, 0, 32'h0,        1, 1, 3'd1, 0, 1, 32'h8000_0000);
    tbl[4]  = v(0, 0, 0, 32'h0,        0, 1, 3'd0, 0, 0, 32'h0);
    tbl[5]  = v(1, 0, 0, 32'h0,        0, 1, 3'd0, 0, 0, 32'h0);
    tbl[6]  = v(1, 0, 0, 32'h4,        1, 1, 3'd1, 0, 1, 32'h0);
    tbl[7]  = v(1, 0, 0, 32'h8,        1, 1, 3'd2, 0, 1, 32'h0);
    tbl[8]  = v(1, 0, 0, 32'hC,        1, 1, 3'd3, 1, 1, 32'h0);
    tbl[9]  = v(1, 0, 0, 32'h10,       1, 0, 3'd4, 1, 1, 32'h0);
    tbl[10] = v(0, 1, 0, 32'h0,        1, 0, 3'd4, 1, 1, 32'h0);
    tbl[11] = v(0, 1, 0, 32'h0,        1, 1, 3'd3, 1, 1, 32'h4);
    tbl[12] = v(0, 1, 0, 32'h0,        1, 1, 3'd2, 0, 1, 32'h8);
    tbl[13] = v(0, 1, 0, 32'h0,        1, 1, 3'd1, 0, 1, 32'hC);
    tbl[14] = v(0, 0, 0, 32'h0,        0, 1, 3'd0, 0, 0, 32'h0);
    tbl[15] = v(1, 0, 0, 32'h100,      0, 1, 3'd0, 0, 0, 32'h0);
    tbl[16] = v(1, 0, 0, 32'h104,      1, 1, 3'd1, 0, 1, 32'h100);
    tbl[17] = v(1, 0, 0, 32'h108,      1, 1, 3'd2, 0, 1, 32'h100);
    tbl[18] = v(1, 1, 1, 32'h10C,      1, 1, 3'd3, 1, 1, 32'h100);
    tbl[19] = v(0, 0, 0, 32'h0,        0, 0, 3'd0, 0, 0, 32'h0);
    tbl[20] = v(0, 0, 0, 32'h0,        0, 1, 3'd0, 0, 0, 32'h0);

    // Reset held for a few cycles, released just after a rising edge.
    repeat (3) tick();
    rst_n = 1'b1;

    // Directed vectors: reset release, single transfer, fill/drain, flush.
    for (int i = 0; i < 21; i++) begin
      s_rdy = tbl[i].s_rdy;
      m_ack = tbl[i].m_ack;
      flush = tbl[i].flush;
      sp    = mk(tbl[i].addr);
      @(negedge clk);
      act = {m_insn, m_addr, m_idata1, m_idata2, m_fdata1, m_fdata2, m_tags};
      chk($sformatf("v%0d_m_rdy", i), 224'(m_rdy), 224'(tbl[i].e_mrdy));
      chk($sformatf("v%0d_s_ack", i), 224'(s_ack), 224'(tbl[i].e_sack));
      chk($sformatf("v%0d_level", i), 224'(level), 224'(tbl[i].e_lvl));
      chk($sformatf("v%0d_s_afull", i), 224'(s_afull), 224'(tbl[i].e_af));
      if (tbl[i].ca) chk($sformatf("v%0d_m_addr", i), 224'(m_addr), 224'(tbl[i].e_maddr));
      if (tbl[i].ca && !tbl[i].e_mrdy) chk($sformatf("v%0d_m_zero", i), act, 224'(0));
      model_step();
      @(posedge clk);
      #1;
    end
    s_rdy = 1'b0; m_ack = 1'b0; flush = 1'b0;
    tick();

    // Streaming: one transfer per cycle across pointer wrap.
    n0 = npop;
    m_ack = 1'b1;
    s_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sp = mk(32'h200 + 32'(i) * 32'd4);
      tick();
    end
    s_rdy = 1'b0;
    tick();
    chk("stream_xfers", 224'(npop - n0), 224'(20));
    m_ack = 1'b0;
    tick();

    // Asynchronous reset in the middle of traffic.
    s_rdy = 1'b1;
    sp = mk(32'h300); tick();
    sp = mk(32'h304); tick();
    rst_n = 1'b0;
    s_rdy = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Random backpressure, 1000 transfers with order and hold checks.
    n0 = npop;
    cyc = 0;
    while ((npop - n0) < 1000 && cyc < 20000) begin
      s_rdy = ($urandom_range(0, 3) != 0);
      m_ack = ($urandom_range(0, 1) != 0);
      flush = ($urandom_range(0, 199) == 0);
      sp    = mk($urandom);
      tick();
      cyc++;
    end
    chk("rand_xfers", 224'((npop - n0) >= 1000), 224'(1));
    s_rdy = 1'b0; flush = 1'b0; m_ack = 1'b1;
    repeat (6) tick();
    chk("drained", 224'(q.size()), 224'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv0_pipe_sbuf.md
Name: rv0_pipe_sbuf

Overview:
Parametrised multi-entry pipeline skid buffer between two core pipeline stages using the rdy/ack handshake. The source asserts rdy; the sink asserts ack; a transfer occurs on any cycle where both are high. The block carries the full stage payload (insn, addr, integer/FP operands, tags) through a DEPTH-entry circular buffer with registered upstream ack, flush, and occupancy reporting. It replaces single-register stage boundaries so that no combinational path runs from downstream ack to upstream ack.

Parameters:
XLEN, 32, integer instruction/operand width
FLEN, 32, FP operand width
DEPTH, 2, entry count; power of two, >= 2
AFULL_LVL, DEPTH-1, level at or above which s_afull asserts; range 1..DEPTH

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline kill; discards all entries
s_insn  in  XLEN  upstream instruction
s_addr  in  32  upstream instruction address
s_idata1, s_idata2  in  XLEN each  upstream integer operands
s_fdata1, s_fdata2  in  FLEN each  upstream FP operands
s_tags  in  32  upstream tags (bpt, ctt, priv, exception bits); passed through unmodified
s_rdy  in  1  upstream payload valid
s_ack  out  1  buffer accepts upstream payload; registered
m_insn, m_addr, m_idata1, m_idata2, m_fdata1, m_fdata2, m_tags  out  widths as s_*  head-entry payload
m_rdy  out  1  head entry valid
m_ack  in  1  downstream accepts head entry
level  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH
s_afull  out  1  level >= AFULL_LVL

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, level=0, m_rdy=0, s_ack=0, s_afull=0, all storage and m_* payload = 0. s_ack rises on the first clk edge after rst_n deasserts.
- Push = s_rdy & s_ack & ~flush. Payload is written at wr_ptr, then wr_ptr += 1 modulo DEPTH.
- Pop = m_rdy & m_ack & ~flush. rd_ptr += 1 modulo DEPTH.
- Pointer width is $clog2(DEPTH). Pointers wrap naturally, with no extra wrap bit; fullness is taken from level.
- level_next = level + push - pop. A simultaneous push and pop leaves level unchanged and is legal at any level, including full-1 and 1.
- s_ack is a register: s_ack <= (level_next < DEPTH) & ~flush. It depends only on state, so m_ack has no combinational path to s_ack.
- When full, s_ack=0. A pop while full raises s_ack on the next cycle.
- m_rdy = (level != 0). m_* is driven combinationally from storage[rd_ptr].
- m_* must hold stable while m_rdy=1 and m_ack=0.
- Latency: a payload pushed in cycle N is visible at m_* with m_rdy=1 in cycle N+1 at the earliest.
- Order is strict FIFO. The sink never sees an entry duplicated or dropped except by flush.
- flush: on the clock edge where flush=1, level, wr_ptr and rd_ptr go to 0 and s_ack goes to 0.
  - Any push or pop in that cycle is discarded: nothing is stored, and m_ack in that cycle has no effect.
  - The cycle after flush: m_rdy=0 and s_ack=0. s_ack returns to 1 the following cycle.
- flush during reset is ignored.
- s_afull is registered from level_next and compared against AFULL_LVL.
- An async reset mid-transfer drops everything, with no partial state.

Optional Feature:
RV0_PIPE_SBUF_BYPASS_EN.
- When defined and level==0 (and flush=0), the upstream payload passes combinationally to m_*, with m_rdy = s_rdy.
- If m_ack=1 in that cycle, the transfer completes with zero latency: nothing is stored and level stays 0.
- If m_ack=0, the payload is stored as a normal push.
- The bypass mux is selected only by level==0, never by m_ack.
- When the macro is undefined, there is no bypass path and minimum latency is 1 cycle as above.

Test Plan:
1. Reset release, DEPTH=2, hold s_rdy=0 → s_ack=0 during reset and rises 1 cycle after rst_n=1; m_rdy=0; level=0; all m_*=0.
2. Push insn=0x00000013, addr=0x80000000, tags=0x1 in cycle N with m_ack=1 → m_rdy=1 with the identical payload in cycle N+1 (cycle N with bypass); level returns to 0 after the pop.
3. DEPTH=4, m_ack=0, push 4 entries addr=0x0,0x4,0x8,0xC:
   - level=4, s_ack=0, s_afull=1 (AFULL_LVL=3).
   - Then assert m_ack=1 → pops in order 0x0,0x4,0x8,0xC.
   - s_ack rises the cycle after the first pop.
4. Continuous s_rdy=1 and m_ack=1 for 20 cycles with addr incrementing by 4 → one transfer per cycle; pointers wrap past DEPTH-1 with no loss; level stays constant.
5. Fill to level=3, then assert flush with s_rdy=1 and m_ack=1 in the same cycle → next cycle level=0, m_rdy=0, s_ack=0; s_ack=1 the cycle after; the flush-cycle payload is never output.
6. Random m_ack toggling while m_rdy=1 → m_* remains stable until accepted; the scoreboard shows strict FIFO order over 1000 transfers.
